// File: rtl/nv_nvdla_glb_intr_csb.sv
// nv_nvdla_glb_intr_csb: CSB register slave for the global interrupt block.
// Owns ping/pong done status, mask and set registers and drives core_intr.
module nv_nvdla_glb_intr_csb #(
    parameter int          NUM_SRC = 8,
    parameter logic [31:0] HW_VER  = 32'h0001_0000
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               csb2glb_req_pvld,
    output logic               csb2glb_req_prdy,
    input  logic [62:0]        csb2glb_req_pd,
    output logic               glb2csb_resp_valid,
    input  logic               glb2csb_resp_ready,
    output logic [33:0]        glb2csb_resp_pd,
    input  logic [NUM_SRC-1:0] done_status0,
    input  logic [NUM_SRC-1:0] done_status1,
    output logic [NUM_SRC-1:0] done_mask0,
    output logic [NUM_SRC-1:0] done_mask1,
    output logic               core_intr
);

    function automatic logic [31:0] src_bits();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            v[i]    = 1'b1;
            v[16+i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [31:0] VALID_BITS = src_bits();

    logic        req_vld_q;
    logic [9:0]  req_addr_q;
    logic [31:0] req_wdat_q;
    logic        req_write_q;
    logic        req_nposted_q;

    logic [31:0] intr_mask;
    logic [31:0] intr_status;
    logic [15:0] intr_cnt;

    logic        stall;
    logic        exec;
    logic        accept;
    logic        sel_ver;
    logic        sel_mask;
    logic        sel_set;
    logic        sel_stat;
    logic        sel_cnt;
    logic        hit;
    logic        wr_en;
    logic        mask_wr;
    logic        set_wr;
    logic        w1c_wr;
    logic        cnt_clr;
    logic        resp_load;
    logic [31:0] rdata;
    logic [31:0] done_vec;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] status_nxt;
    logic [31:0] mask_nxt;
    logic        intr_nxt;
    logic        intr_rise;
    logic [15:0] cnt_nxt;

    // Byte enables, level and upper address bits carry no meaning here.
    logic unused_req_bits;
    assign unused_req_bits = ^{csb2glb_req_pd[62:56], csb2glb_req_pd[21:10]};

    assign stall            = glb2csb_resp_valid & ~glb2csb_resp_ready;
    assign exec             = req_vld_q & ~stall;
    assign csb2glb_req_prdy = ~req_vld_q | ~stall;
    assign accept           = csb2glb_req_pvld & csb2glb_req_prdy;

    assign sel_ver  = req_addr_q == 10'd0;
    assign sel_mask = req_addr_q == 10'd1;
    assign sel_set  = req_addr_q == 10'd2;
    assign sel_stat = req_addr_q == 10'd3;
    assign sel_cnt  = req_addr_q == 10'd4;
    assign hit      = sel_ver | sel_mask | sel_set | sel_stat | sel_cnt;

    assign wr_en     = exec & req_write_q;
    assign mask_wr   = wr_en & sel_mask;
    assign set_wr    = wr_en & sel_set;
    assign w1c_wr    = wr_en & sel_stat;
    assign cnt_clr   = wr_en & sel_cnt;
    assign resp_load = exec & (~req_write_q | req_nposted_q);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ver:  rdata = HW_VER;
            sel_mask: rdata = intr_mask;
            sel_stat: rdata = intr_status;
            sel_cnt:  rdata = {16'h0, intr_cnt};
            default:  rdata = '0;
        endcase
    end

    always_comb begin
        done_vec                 = '0;
        done_vec[NUM_SRC-1:0]    = done_status0;
        done_vec[16 +: NUM_SRC]  = done_status1;
    end

    // Clearing first lets a same-cycle done pulse or set win over W1C.
    assign set_vec    = set_wr ? req_wdat_q : '0;
    assign clr_vec    = w1c_wr ? req_wdat_q : '0;
    assign status_nxt = ((intr_status & ~clr_vec) | done_vec | set_vec)
                        & VALID_BITS;
    assign mask_nxt   = mask_wr ? (req_wdat_q & VALID_BITS) : intr_mask;
    assign intr_nxt   = |(status_nxt & ~mask_nxt);
    assign intr_rise  = intr_nxt & ~core_intr;

    always_comb begin
        cnt_nxt = intr_cnt;
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (intr_rise && intr_cnt != 16'hFFFF) begin
            cnt_nxt = intr_cnt + 16'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_vld_q     <= 1'b0;
            req_addr_q    <= '0;
            req_wdat_q    <= '0;
            req_write_q   <= 1'b0;
            req_nposted_q <= 1'b0;
        end else if (accept) begin
            req_vld_q     <= 1'b1;
            req_addr_q    <= csb2glb_req_pd[9:0];
            req_wdat_q    <= csb2glb_req_pd[53:22];
            req_write_q   <= csb2glb_req_pd[54];
            req_nposted_q <= csb2glb_req_pd[55];
        end else if (exec) begin
            req_vld_q     <= 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            glb2csb_resp_valid <= 1'b0;
            glb2csb_resp_pd    <= '0;
        end else if (resp_load) begin
            glb2csb_resp_valid <= 1'b1;
            glb2csb_resp_pd    <= {req_write_q, ~hit,
                                   req_write_q ? 32'h0 : rdata};
        end else if (glb2csb_resp_ready) begin
            glb2csb_resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            intr_mask   <= '0;
            intr_status <= '0;
            intr_cnt    <= '0;
            core_intr   <= 1'b0;
        end else begin
            intr_mask   <= mask_nxt;
            intr_status <= status_nxt;
            intr_cnt    <= cnt_nxt;
            core_intr   <= intr_nxt;
        end
    end

    assign done_mask0 = intr_mask[NUM_SRC-1:0];
    assign done_mask1 = intr_mask[16 +: NUM_SRC];

endmodule
